fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Owns the program counter and sequences the instruction-fetch stage.
- Issues instruction-memory reads and advances the PC on ihit.
- Applies branch/jump redirects, including a redirect that arrives during an outstanding I-cache miss.
- Freezes on pipeline stall and parks fetch permanently on halt.
- Sits between the IF/ID latch, the I-cache and the hazard/branch-resolution logic in each core.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, address/word width (word_t)

Ports:
CLK  input  1  clock
nRST  input  1  synchronous active-low reset, sampled on rising CLK
ihit  input  1  I-cache returns valid instruction for imemaddr this cycle
stall  input  1  hazard unit freezes IF (IF/ID must hold)
pc_cntrl  input  1  redirect request from branch resolution
final_memaddr  input  ADDR_W  redirect target
halt  input  1  halt detected in pipeline
halt_mem  input  1  halt reached memory stage
imemREN  output  1  instruction read enable
imemaddr  output  ADDR_W  instruction fetch address (= PC)
if_valid  output  1  fetched instruction may be latched into IF/ID this cycle
next_memaddr  output  ADDR_W  imemaddr + 4, to IF/ID for link/branch math
halted  output  1  fetch permanently stopped
fetch_count  output  32  number of cycles with if_valid=1

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is synchronous and active-low; all state updates on rising CLK.
- Reset (nRST=0 at edge):
  - pc=PC_INIT, state=FETCH, pend_addr=0, fetch_count=0.
  - First cycle after reset: imemREN=1, imemaddr=PC_INIT, if_valid=ihit&~stall, halted=0.
  - Reset mid-miss or mid-pending-redirect abandons everything; no pending redirect survives reset.
- Combinational outputs:
  - imemaddr=pc.
  - next_memaddr=pc+4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
  - imemREN=(state!=HALT).
  - halted=(state==HALT).
  - halt_req=halt|halt_mem.
- Address alignment: redirect targets are loaded with bits[1:0] forced to 00.
- State FETCH, evaluated in priority order:
  1. halt_req: go to HALT, pc holds, if_valid=0. The in-flight instruction is dropped.
  2. pc_cntrl & ihit: pc<=final_memaddr, if_valid=0 (wrong-path instruction squashed). Overrides stall. Target is fetched the next cycle (1-cycle redirect latency).
  3. pc_cntrl & ~ihit: pend_addr<=final_memaddr, go to MISS_REDIR, pc holds. The cache sees a stable address until its fill completes.
  4. ihit & ~stall: pc<=pc+4, if_valid=1.
  5. Otherwise (miss, or stall): pc holds, if_valid=0.
- State MISS_REDIR:
  - imemaddr holds the old pc; if_valid=0 always.
  - halt_req (highest priority): go to HALT; pend_addr discarded.
  - pc_cntrl again: pend_addr<=final_memaddr (latest redirect wins).
  - ihit: pc<=pend_addr, go to FETCH. If pc_cntrl is also high in that cycle, pc<=final_memaddr instead.
  - stall has no effect in this state.
- State HALT: imemREN=0, if_valid=0, pc frozen, halted=1. Absorbing; exit only via reset. pc_cntrl, ihit and stall are ignored.
- fetch_count: increments by 1 on each cycle with if_valid=1; wraps 0xFFFF_FFFF to 0.
- Invariants:
  - if_valid implies ihit & ~stall & ~pc_cntrl & ~halt_req & state==FETCH.
  - pc changes only on an ihit cycle (never during an outstanding miss).
- Illegal state encoding: recover to FETCH on the next edge.

Test Plan:
- Reset then ihit=1 for 4 cycles, stall=0 -> imemaddr 0x0,0x4,0x8,0xC; if_valid=1 each cycle; fetch_count=4.
- At pc=0x10: stall=1 for 2 cycles with ihit=1, then release -> imemaddr stays 0x10, if_valid=0 during stall, next cycle advances to 0x14.
- pc=0x20, ihit=1, pc_cntrl=1, final_memaddr=0x103 -> if_valid=0 that cycle; next imemaddr=0x100; fetch_count unchanged.
- pc=0x40 miss (ihit=0), pc_cntrl=1 with 0x200, then 0x300 one cycle later, ihit after 5 cycles -> imemaddr stays 0x40 throughout, if_valid=0; cycle after ihit, imemaddr=0x300.
- halt_mem=1 during MISS_REDIR with pending 0x80 -> next cycle halted=1, imemREN=0; subsequent ihit/pc_cntrl do not change imemaddr.
- nRST=0 asserted mid-miss at pc=0x50 (with PC_INIT=0x400) -> after the edge imemaddr=0x400, state FETCH, fetch_count=0, no pending redirect applied.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and sequences the instruction-fetch stage.
// It issues I-cache reads at pc and advances pc by 4 on each accepted ihit. It applies
// branch/jump redirects, including one that arrives while an I-cache miss is still
// outstanding. It freezes on a pipeline stall and parks fetch permanently on halt.
//
// Ports:
//   CLK            clock
//   nRST           synchronous active-low reset, sampled on rising CLK
//   ihit           I-cache returns a valid instruction for imemaddr this cycle
//   stall          hazard unit freezes IF (IF/ID must hold)
//   pc_cntrl       redirect request from branch resolution
//   final_memaddr  redirect target (bits [1:0] are forced to 00)
//   halt           halt detected in the pipeline
//   halt_mem       halt reached the memory stage
//   imemREN        instruction read enable
//   imemaddr       instruction fetch address (= pc)
//   if_valid       fetched instruction may be latched into IF/ID this cycle
//   next_memaddr   imemaddr + 4, for link/branch math downstream
//   halted         fetch permanently stopped
//   fetch_count    number of cycles with if_valid = 1
module fetch_sequencer #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              stall,
    input  logic              pc_cntrl,
    input  logic [ADDR_W-1:0] final_memaddr,
    input  logic              halt,
    input  logic              halt_mem,
    output logic              imemREN,
    output logic [ADDR_W-1:0] imemaddr,
    output logic              if_valid,
    output logic [ADDR_W-1:0] next_memaddr,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam int unsigned       CNT_W   = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        FETCH      = 2'b00,
        MISS_REDIR = 2'b01,
        HALT       = 2'b10
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [ADDR_W-1:0]  pend_addr, pend_addr_n;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_n;
    logic               halt_req;
    logic [ADDR_W-1:0]  redir_addr;

    assign halt_req     = halt | halt_mem;
    assign redir_addr   = {final_memaddr[ADDR_W-1:2], 2'b00};

    // Outputs derived directly from registered state
    assign imemaddr     = pc;
    assign next_memaddr = pc + PC_STEP;
    assign imemREN      = (state != HALT);
    assign halted       = (state == HALT);
    assign fetch_count  = fetch_cnt_q;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            pend_addr   <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_addr   <= pend_addr_n;
            fetch_cnt_q <= fetch_cnt_n;
        end
    end

    // Next-state, pc update and fetch-valid decision
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_addr_n = pend_addr;
        if_valid    = 1'b0;

        unique case (state)
            FETCH: begin
                if (halt_req) begin
                    state_n = HALT;
                end else if (pc_cntrl && ihit) begin
                    // Wrong-path instruction squashed; target fetched next cycle
                    pc_n = redir_addr;
                end else if (pc_cntrl) begin
                    // Keep the cache address stable until its fill completes
                    pend_addr_n = redir_addr;
                    state_n     = MISS_REDIR;
                end else if (ihit && !stall) begin
                    pc_n     = pc + PC_STEP;
                    if_valid = 1'b1;
                end
            end

            MISS_REDIR: begin
                if (halt_req) begin
                    state_n     = HALT;
                    pend_addr_n = '0;
                end else begin
                    if (pc_cntrl) begin
                        pend_addr_n = redir_addr;
                    end
                    if (ihit) begin
                        // A redirect arriving with the fill is the newest one
                        pc_n    = pc_cntrl ? redir_addr : pend_addr;
                        state_n = FETCH;
                    end
                end
            end

            HALT: begin
                state_n = HALT;
            end

            default: begin
                state_n = FETCH;
            end
        endcase

        fetch_cnt_n = fetch_cnt_q + CNT_W'(if_valid);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations. A second instance
// with PC_INIT = 0x400 shares the stimulus. It is used to check the reset value of pc.
module tb_fetch_sequencer;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        stall;
    logic        pc_cntrl;
    logic [31:0] final_memaddr;
    logic        halt;
    logic        halt_mem;

    logic        imemREN,   imemREN_b;
    logic [31:0] imemaddr,  imemaddr_b;
    logic        if_valid,  if_valid_b;
    logic [31:0] next_memaddr, next_memaddr_b;
    logic        halted,    halted_b;
    logic [31:0] fetch_count, fetch_count_b;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer #(.ADDR_W(32), .PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .pc_cntrl(pc_cntrl),
        .final_memaddr(final_memaddr), .halt(halt), .halt_mem(halt_mem),
        .imemREN(imemREN), .imemaddr(imemaddr), .if_valid(if_valid),
        .next_memaddr(next_memaddr), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_sequencer #(.ADDR_W(32), .PC_INIT(32'h0000_0400)) dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .pc_cntrl(pc_cntrl),
        .final_memaddr(final_memaddr), .halt(halt), .halt_mem(halt_mem),
        .imemREN(imemREN_b), .imemaddr(imemaddr_b), .if_valid(if_valid_b),
        .next_memaddr(next_memaddr_b), .halted(halted_b), .fetch_count(fetch_count_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; stall = 1'b0; pc_cntrl = 1'b0;
        final_memaddr = '0; halt = 1'b0; halt_mem = 1'b0;
        step();
        nRST = 1'b1;
        settle();
        check("rst_addr",   imemaddr, 32'h0);
        check("rst_ren",    32'(imemREN), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count",  fetch_count, 32'd0);
        check("rst_valid",  32'(if_valid), 32'd0);
        check("rst_next",   next_memaddr, 32'h4);

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            ihit = 1'b1;
            settle();
            check("seq_addr",  imemaddr, 32'(4 * i));
            check("seq_valid", 32'(if_valid), 32'd1);
            step();
        end
        check("seq_count", fetch_count, 32'd4);
        check("seq_pc10",  imemaddr, 32'h10);

        // Stall holds pc with ihit present
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("stall_addr",  imemaddr, 32'h10);
            check("stall_valid", 32'(if_valid), 32'd0);
            step();
        end
        stall = 1'b0;
        settle();
        check("unstall_valid", 32'(if_valid), 32'd1);
        step();
        check("unstall_addr",  imemaddr, 32'h14);
        check("unstall_count", fetch_count, 32'd5);
        step(); step(); step();
        check("at_20", imemaddr, 32'h20);

        // Redirect with ihit: squash, 1-cycle latency, target aligned
        pc_cntrl = 1'b1; final_memaddr = 32'h103;
        settle();
        check("redir_valid", 32'(if_valid), 32'd0);
        step();
        check("redir_addr",  imemaddr, 32'h100);
        check("redir_count", fetch_count, 32'd8);
        final_memaddr = 32'h40;
        step();
        check("at_40", imemaddr, 32'h40);

        // Redirect during miss, newer redirect wins, stall ignored
        ihit = 1'b0; pc_cntrl = 1'b1; final_memaddr = 32'h200;
        settle();
        check("miss_valid0", 32'(if_valid), 32'd0);
        step();
        final_memaddr = 32'h300;
        settle();
        check("miss_hold1", imemaddr, 32'h40);
        step();
        pc_cntrl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            settle();
            check("miss_hold", imemaddr, 32'h40);
            check("miss_valid", 32'(if_valid), 32'd0);
            step();
        end
        stall = 1'b0; ihit = 1'b1;
        settle();
        check("miss_fill_valid", 32'(if_valid), 32'd0);
        check("miss_fill_addr",  imemaddr, 32'h40);
        step();
        ihit = 1'b0;
        settle();
        check("miss_target", imemaddr, 32'h300);
        check("miss_count",  fetch_count, 32'd8);

        // Redirect arriving together with the fill overrides the pending one
        pc_cntrl = 1'b1; final_memaddr = 32'h500;
        step();
        ihit = 1'b1; final_memaddr = 32'h604;
        step();
        check("fill_redir", imemaddr, 32'h604);

        // next_memaddr wraps at the top of the address space
        final_memaddr = 32'hFFFF_FFFF;
        step();
        pc_cntrl = 1'b0;
        settle();
        check("top_addr",  imemaddr, 32'hFFFF_FFFC);
        check("wrap_next", next_memaddr, 32'h0);
        check("top_valid", 32'(if_valid), 32'd1);
        step();
        check("wrap_addr",  imemaddr, 32'h0);
        check("wrap_count", fetch_count, 32'd9);

        // halt_mem during a pending redirect parks fetch
        ihit = 1'b0; pc_cntrl = 1'b1; final_memaddr = 32'h80;
        step();
        pc_cntrl = 1'b0; halt_mem = 1'b1;
        settle();
        check("hreq_valid", 32'(if_valid), 32'd0);
        step();
        halt_mem = 1'b0;
        settle();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_ren",    32'(imemREN), 32'd0);
        check("halt_addr",   imemaddr, 32'h0);
        ihit = 1'b1; pc_cntrl = 1'b1; final_memaddr = 32'h80;
        settle();
        check("halt_valid", 32'(if_valid), 32'd0);
        step(); step();
        check("halt_frozen", imemaddr, 32'h0);
        check("halt_stays",  32'(halted), 32'd1);
        check("halt_count",  fetch_count, 32'd9);

        // Reset mid-miss abandons the pending redirect
        nRST = 1'b0; ihit = 1'b0; pc_cntrl = 1'b0;
        step();
        nRST = 1'b1; ihit = 1'b1; pc_cntrl = 1'b1; final_memaddr = 32'h50;
        step();
        ihit = 1'b0; final_memaddr = 32'h80;
        settle();
        check("b_at_50", imemaddr_b, 32'h50);
        step();
        pc_cntrl = 1'b0; nRST = 1'b0;
        step();
        nRST = 1'b1;
        settle();
        check("b_rst_addr",   imemaddr_b, 32'h400);
        check("b_rst_count",  fetch_count_b, 32'd0);
        check("b_rst_halted", 32'(halted_b), 32'd0);
        check("a_rst_addr",   imemaddr, 32'h0);
        ihit = 1'b1;
        settle();
        check("b_rst_valid", 32'(if_valid_b), 32'd1);
        step();
        check("b_no_pending", imemaddr_b, 32'h404);
        check("b_count1",     fetch_count_b, 32'd1);

        // halt in FETCH drops the in-flight instruction
        halt = 1'b1;
        settle();
        check("fetch_halt_valid", 32'(if_valid), 32'd0);
        step();
        halt = 1'b0; ihit = 1'b0;
        check("fetch_halt_halted", 32'(halted), 32'd1);
        check("fetch_halt_addr",   imemaddr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
